// File: rtl/nes_bus_defs.sv
// nes_bus_defs: shared 2A03 bus addresses and OAM DMA state encoding
package nes_bus_defs;
  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
endpackage

// File: rtl/oam_dma_fsm.sv
// oam_dma_fsm: OAM DMA sequencing registers (state, count, page, latch, parity)
// DMA_ODD_ALIGN_EN: insert one ALIGN cycle so the first READ lands on a get cycle
module oam_dma_fsm
  import nes_bus_defs::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = ADDR_OAMDMA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_data_in,
  output logic [2:0]  state,
  output logic [7:0]  count,
  output logic [7:0]  page,
  output logic [7:0]  latch
);
  logic [2:0] halt_next;
`ifdef DMA_ODD_ALIGN_EN
  logic parity;
  always_ff @(posedge clock)
    parity <= reset ? 1'b0 : ~parity;
  // the cycle after HALT would be a put cycle when parity is 0 now, so pad it
  assign halt_next = parity ? READ : ALIGN;
`else
  assign halt_next = READ;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'h00;
      page  <= 8'h00;
      latch <= 8'h00;
    end else begin
      case (state)
        IDLE:
          if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
            page  <= cpu_data_out;
            state <= HALT;
          end
        HALT:  state <= halt_next;
        ALIGN: state <= READ;
        READ: begin
          latch <= bus_data_in;
          state <= WRITE;
        end
        WRITE: begin
          count <= count + 8'h01;
          state <= (count == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: sprite DMA controller and 2A03 bus arbiter, CPU passthrough when idle
// DMA_ODD_ALIGN_EN: enables the odd-cycle ALIGN state in oam_dma_fsm
module oam_dma_arbiter
  import nes_bus_defs::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = ADDR_OAMDMA,
  parameter logic [15:0] TARGET_ADDR  = ADDR_OAMDATA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_rw,
  input  logic [7:0]  bus_data_in,
  output logic        dma_active
);
  logic [2:0] state;
  logic [7:0] count, page, latch;
  oam_dma_fsm #(.TRIGGER_ADDR(TRIGGER_ADDR)) u_fsm (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_rw(cpu_rw), .bus_data_in(bus_data_in), .state(state), .count(count),
    .page(page), .latch(latch)
  );
  // HALT and ALIGN issue a dummy read at the halted CPU's address
  always_comb begin
    bus_addr     = (state == READ) ? {page, count} : (state == WRITE) ? TARGET_ADDR : cpu_addr;
    bus_rw       = (state == IDLE) ? cpu_rw : (state != WRITE);
    bus_data_out = (state == WRITE) ? latch : cpu_data_out;
  end
  assign cpu_rdy    = (state == IDLE);
  assign dma_active = (state != IDLE);
endmodule
